// File: rtl/picorv_print_fifo_if.sv
// rtl/picorv_print_fifo_if.sv - picorv32 snoop bus and character output stream bundle
interface picorv_print_fifo_if #(
  parameter int NUM_CHAN = 4,
  localparam int CW = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1
);
  logic          mem_valid;
  logic          mem_ready;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wstrb;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_chan;
  logic [7:0]    out_data;
  logic          out_eol;

  modport master (
    output mem_valid, mem_ready, mem_addr, mem_wdata, mem_wstrb, out_ready,
    input  out_valid, out_chan, out_data, out_eol
  );

  modport slave (
    input  mem_valid, mem_ready, mem_addr, mem_wdata, mem_wstrb, out_ready,
    output out_valid, out_chan, out_data, out_eol
  );
endinterface

// File: rtl/picorv_print_fifo.sv
// rtl/picorv_print_fifo.sv - multi-channel console capture FIFO snooping the picorv32 bus
module picorv_print_fifo #(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int          NUM_CHAN  = 4,
  parameter int          DEPTH     = 16,
  localparam int         CW        = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1,
  localparam int         AW        = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  picorv_print_fifo_if.slave   bus,
  output logic [AW:0]          fill_level,
  output logic                 overflow,
  output logic [15:0]          drop_count,
  input  logic                 clear_stats
);

  logic [CW+7:0] fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [CW-1:0] hit_chan;
  logic          hit;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push_ok;
  logic          drop;
  logic [CW+7:0] head;
  logic          unused_bits;

  assign unused_bits = ^{bus.mem_wdata[31:8], bus.mem_addr[1:0], bus.mem_wstrb[3:1]};

  // BASE_ADDR alignment lets the window be decoded as tag match plus index range check
  assign hit_chan = bus.mem_addr[2+CW-1:2];
  assign hit = bus.mem_valid && bus.mem_ready && bus.mem_wstrb[0]
            && (bus.mem_addr[31:2+CW] == BASE_ADDR[31:2+CW])
            && ({1'b0, hit_chan} < (CW+1)'(NUM_CHAN));

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop     = !empty && bus.out_ready;
  assign push_ok = hit && (!full || pop) && !reset;
  assign drop    = hit && full && !pop;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= {hit_chan, bus.mem_wdata[7:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A drop wins over a coincident clear so the lost character is still reported
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clear_stats)                drop_count <= 16'd1;
      else if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end else if (clear_stats) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

  assign head          = fifo_mem[rd_ptr];
  assign bus.out_valid = !empty;
  assign bus.out_chan  = empty ? '0 : head[CW+7:8];
  assign bus.out_data  = empty ? '0 : head[7:0];
  assign bus.out_eol   = !empty && (head[7:0] == 8'h0A);
  assign fill_level    = count;

endmodule

// File: tb/tb_picorv_print_fifo.sv
// tb/tb_picorv_print_fifo.sv - directed scoreboard bench for picorv_print_fifo
module tb_picorv_print_fifo;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear_stats = 1'b0;
  logic [4:0]  fill_level;
  logic        overflow;
  logic [15:0] drop_count;

  int checks = 0;
  int failures = 0;
  logic [10:0] sb[$];

  picorv_print_fifo_if #(.NUM_CHAN(4)) bus ();

  picorv_print_fifo #(.BASE_ADDR(BASE), .NUM_CHAN(4), .DEPTH(16)) dut (
    .clk(clk), .reset(reset), .bus(bus), .fill_level(fill_level),
    .overflow(overflow), .drop_count(drop_count), .clear_stats(clear_stats)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] mk(input int ch, input logic [7:0] d);
    logic [1:0] c;
    c = ch[1:0];
    return {c, d, d == 8'h0A};
  endfunction

  // Model pops before it pushes, so an empty FIFO never pops the entry it is receiving
  task automatic tick(input bit push, input logic [10:0] ent);
    logic [10:0] exp_head;
    if (bus.out_ready && sb.size() > 0) begin
      exp_head = sb.pop_front();
      check("pop_valid", 32'(bus.out_valid), 32'd1);
      check("pop_head", 32'({bus.out_chan, bus.out_data, bus.out_eol}), 32'(exp_head));
    end
    if (push) sb.push_back(ent);
    @(posedge clk);
    #1;
    check("fill_level", 32'(fill_level), 32'(sb.size()));
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d, input logic [3:0] s,
                    input bit v, input bit r, input bit acc, input int ch);
    bus.mem_addr  = a;
    bus.mem_wdata = {24'hABCDEF, d};
    bus.mem_wstrb = s;
    bus.mem_valid = v;
    bus.mem_ready = r;
    tick(acc, mk(ch, d));
    bus.mem_valid = 1'b0;
    bus.mem_ready = 1'b0;
    bus.mem_wstrb = 4'b0000;
  endtask

  initial begin
    bus.mem_valid = 1'b0;
    bus.mem_ready = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wstrb = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_fill", 32'(fill_level), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_drops", 32'(drop_count), 32'd0);
    check("rst_head", 32'({bus.out_chan, bus.out_data, bus.out_eol}), 32'd0);

    wr(BASE, 8'h41, 4'b0001, 1, 1, 1, 0);
    check("first_valid", 32'(bus.out_valid), 32'd1);
    check("first_chan", 32'(bus.out_chan), 32'd0);
    check("first_data", 32'(bus.out_data), 32'h41);
    for (int i = 0; i < 5; i++) begin
      tick(0, '0);
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_head", 32'({bus.out_chan, bus.out_data, bus.out_eol}), 32'(mk(0, 8'h41)));
    end
    bus.out_ready = 1'b1;
    tick(0, '0);

    wr(BASE + 32'h8, 8'h41, 4'b0001, 1, 1, 1, 2);
    check("ch2_eol", 32'(bus.out_eol), 32'd0);
    wr(BASE + 32'hC, 8'h0A, 4'b0001, 1, 1, 1, 3);
    check("ch3_eol", 32'(bus.out_eol), 32'd1);
    tick(0, '0);
    check("pair_drained", 32'(bus.out_valid), 32'd0);

    bus.out_ready = 1'b0;
    wr(BASE,           8'h55, 4'b0000, 1, 1, 0, 0);
    check("neg_read", 32'(bus.out_valid), 32'd0);
    wr(BASE + 32'h10,  8'h55, 4'b0001, 1, 1, 0, 0);
    check("neg_range", 32'(bus.out_valid), 32'd0);
    wr(BASE,           8'h55, 4'b0010, 1, 1, 0, 0);
    check("neg_strb", 32'(bus.out_valid), 32'd0);
    wr(BASE,           8'h55, 4'b0001, 1, 0, 0, 0);
    check("neg_notready", 32'(bus.out_valid), 32'd0);

    for (int i = 0; i < 16; i++) wr(BASE + 32'(4 * (i % 4)), 8'(i + 8'h20), 4'b0001, 1, 1, 1, i % 4);
    for (int i = 0; i < 3; i++)  wr(BASE + 32'h4, 8'h99, 4'b0001, 1, 1, 0, 1);
    check("full_overflow", 32'(overflow), 32'd1);
    check("full_drops", 32'(drop_count), 32'd3);
    bus.out_ready = 1'b1;
    wr(BASE + 32'h4, 8'h77, 4'b0011, 1, 1, 1, 1);
    bus.out_ready = 1'b0;
    check("fullpop_drops", 32'(drop_count), 32'd3);
    check("fullpop_overflow", 32'(overflow), 32'd1);
    clear_stats = 1'b1;
    tick(0, '0);
    clear_stats = 1'b0;
    check("clear_overflow", 32'(overflow), 32'd0);
    check("clear_drops", 32'(drop_count), 32'd0);
    clear_stats = 1'b1;
    wr(BASE, 8'h66, 4'b0001, 1, 1, 0, 0);
    clear_stats = 1'b0;
    check("clrdrop_overflow", 32'(overflow), 32'd1);
    check("clrdrop_drops", 32'(drop_count), 32'd1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 24 && sb.size() > 0; i++) tick(0, '0);
    check("drain_empty", 32'(bus.out_valid), 32'd0);
    clear_stats = 1'b1;
    tick(0, '0);
    clear_stats = 1'b0;

    for (int i = 0; i < 40; i++) begin
      bus.out_ready = (sb.size() >= 15) ? 1'b1 : 1'($urandom_range(0, 1));
      wr(BASE + 32'(4 * (i % 4)), 8'($urandom_range(0, 255)), 4'b1111, 1, 1, 1, i % 4);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 24 && sb.size() > 0; i++) tick(0, '0);
    check("stream_empty", 32'(bus.out_valid), 32'd0);
    check("stream_drops", 32'(drop_count), 32'd0);

    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) wr(BASE + 32'h8, 8'(8'h30 + i), 4'b0001, 1, 1, 1, 2);
    check("prereset_valid", 32'(bus.out_valid), 32'd1);
    reset = 1'b1;
    bus.out_ready = 1'b1;
    sb.delete();
    wr(BASE + 32'hC, 8'h5A, 4'b0001, 1, 1, 0, 3);
    reset = 1'b0;
    check("reset_valid", 32'(bus.out_valid), 32'd0);
    check("reset_fill", 32'(fill_level), 32'd0);
    tick(0, '0);
    check("reset_nocapture", 32'(bus.out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/picorv_print_fifo.md
# picorv_print_fifo

Memory-mapped, multi-channel console capture block that snoops the picorv32 native memory bus. It replaces the single-byte, one-cycle print pulse with NUM_CHAN print channels, a DEPTH-entry FIFO, a valid/ready output stream, and overflow accounting. It sits beside picorv_mem in the CPU wrapper, observes completed writes only, and never drives the memory bus.

## Interface
- BASE_ADDR, 32'h1000_0000, byte address of channel 0; must be aligned to 4*2^CW.
- NUM_CHAN, 4, number of print channels (1..16). Channel k is at BASE_ADDR + 4*k.
- DEPTH, 16, FIFO entries; power of two, at least 2.
- CW (localparam), max(1, clog2(NUM_CHAN)), channel index width.
- AW (localparam), clog2(DEPTH), FIFO pointer width.

Ports:
- clk  in  1  sole clock; everything is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_valid  in  1  picorv32 bus valid.
- mem_ready  in  1  memory ready; a transfer completes when mem_valid && mem_ready.
- mem_addr  in  32  bus address.
- mem_wdata  in  32  write data; only bits [7:0] are captured.
- mem_wstrb  in  4  write strobes; bit 0 must be set for capture.
- out_valid  out  1  FIFO head entry is valid.
- out_ready  in  1  consumer accepts the head entry.
- out_chan  out  CW  channel of the head entry.
- out_data  out  8  character of the head entry.
- out_eol  out  1  head character equals 8'h0A.
- fill_level  out  AW+1  number of occupied entries (0..DEPTH).
- overflow  out  1  sticky flag: at least one character was dropped.
- drop_count  out  16  dropped characters, saturating at 16'hFFFF.
- clear_stats  in  1  single-cycle clear of overflow and drop_count.

## Operation
- A hit is mem_valid && mem_ready && mem_wstrb[0] && mem_addr[31:2] == BASE_ADDR[31:2] + k, for some k < NUM_CHAN.
  - mem_addr[1:0] is ignored.
  - Reads (mem_wstrb == 0) are ignored, as are writes with mem_wstrb[0] == 0.
  - Addresses outside the window are ignored.
- On a hit, the entry {k, mem_wdata[7:0]} is pushed.
- Push rules:
  - Not full: the push is accepted.
  - Full with a pop in the same cycle: the push is accepted and fill_level stays at DEPTH.
  - Full with no pop: the character is dropped, overflow is set to 1, and drop_count increments (saturating).
- Pop is out_valid && out_ready. out_ready while empty has no effect.
- The FIFO is first-word-fall-through. out_chan, out_data and out_eol always reflect the head entry and are stable while out_valid && !out_ready.
- Per-channel ordering and global arrival order are both preserved. There is one shared FIFO.
- Pointers wrap modulo DEPTH. full is fill_level == DEPTH; empty is fill_level == 0.
- clear_stats zeroes overflow and drop_count.
  - If a drop occurs in the same cycle as clear_stats: drop_count = 1 and overflow = 1.
- Reset values: out_valid 0, fill_level 0, overflow 0, drop_count 0. out_chan, out_data and out_eol are 0 while empty.
- Reset mid-operation discards all entries. A pending head entry is not delivered, and a hit coincident with reset is not captured.

## Timing
- Hit in cycle N: the entry is visible to the consumer at cycle N+1, with out_valid = 1 if the FIFO was empty. fill_level updates at N+1.
- Pop in cycle N: the next entry is at the head in cycle N+1. out_valid falls at N+1 if it was the last entry.
- Simultaneous push and pop when not empty: fill_level is unchanged.
- Simultaneous push and pop when empty: the push is accepted and the pop is void, because out_valid was 0.
- overflow and drop_count update at N+1 after the dropping cycle.
- Sustained throughput is one character per cycle in and one per cycle out.
- All outputs are registered or decoded from registered state. There is no combinational path from mem_* or out_ready to any output.

## Test plan
- Reset, then write 8'h41 to channel 0 (addr 32'h1000_0000, wstrb 4'b0001) with out_ready = 0:
  - next cycle: out_valid = 1, out_chan = 0, out_data = 8'h41, fill_level = 1.
  - hold for 5 cycles: outputs stay stable.
- Write "A" to channel 2 (32'h1000_0008), then 8'h0A to channel 3 (32'h1000_000C), with out_ready = 1:
  - pops in order {2, 41}, then {3, 0A}.
  - out_eol = 1 only on the second pop.
- Negative cases: a read (wstrb 0) at 32'h1000_0000, a write at 32'h1000_0010 (channel index 4, out of range), a write with wstrb 4'b0010, and mem_valid with mem_ready = 0.
  - For all four: out_valid stays 0 and fill_level stays 0.
- Fill 16 entries with out_ready = 0, then write 3 more:
  - fill_level = 16, overflow = 1, drop_count = 3.
  - Write once more together with a single pop: accepted, fill_level remains 16, drop_count remains 3.
  - Assert clear_stats: overflow = 0, drop_count = 0.
- Streaming: 40 back-to-back writes, alternating channels, with random out_ready:
  - all 40 entries are received in order with no drops.
  - pointer wrap-around is exercised.
- Reset with 5 entries queued and out_valid = 1, while a hit arrives in the reset cycle:
  - next cycle: out_valid = 0, fill_level = 0, and the coincident hit is not captured.
